axis_dc_restore: RTL and testbench

//  Inverse of the DC-removal stage: accepts the packed {DC16, AC16} stream and restores the full signal as AC + DC.
//  The DC term is taken from the stream, from a manual register, or frozen, and is slew-limited to avoid output steps.

---
 rtl/axis_dc_restore.sv | 235 +++++++++++++++++++++++
 tb/tb_axis_dc_restore.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dc_restore.sv
// ---------------------------------------------------------------------------
// axis_dc_restore
//
// Rebuilds a full-scale signal from the packed {DC, AC} stream produced by the
// DC-removal stage: out = AC + DC_applied. The applied DC follows the stream
// DC, a manual target, or is frozen. Each change is limited to dc_slew per
// accepted beat so that switching source does not step the DAC.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   S_AXIS_ACDC_*          input stream, tdata = {DC[31:16], AC[15:0]} signed
//   dc_mode                0 stream DC, 1 manual DC, 2/3 freeze
//   dc_manual              manual DC target (signed)
//   dc_slew                max |DC change| per accepted beat, 0 = unlimited
//   sat_clr                one-cycle pulse, clears sat_count
//   M_AXIS_*               saturated restored sample (signed)
//   M_AXIS_WIDE_tdata      unsaturated sum, sign-extended to 32 bits
//   sat_count              clamped output beats, sticks at all-ones
//   dbg_dc_applied         DC value currently applied (stage 1)
//
// DC state machine (advances only on accepted input beats)
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_INIT   | no beat seen since reset; first beat loads DC without slew
//   ST_TRACK  | DC slews toward the stream or manual target
//   ST_FREEZE | DC held at its last value
//
// SLEW_WIDTH must not exceed DATA_WIDTH; DATA_WIDTH + 1 must not exceed 32.
// ---------------------------------------------------------------------------
module axis_dc_restore #(
   parameter int DATA_WIDTH    = 16,
   parameter int SLEW_WIDTH    = 16,
   parameter int SAT_CNT_WIDTH = 16
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [2*DATA_WIDTH-1:0]   S_AXIS_ACDC_tdata,
   input  logic                      S_AXIS_ACDC_tvalid,
   output logic                      S_AXIS_ACDC_tready,
   input  logic [1:0]                dc_mode,
   input  logic [DATA_WIDTH-1:0]     dc_manual,
   input  logic [SLEW_WIDTH-1:0]     dc_slew,
   input  logic                      sat_clr,
   output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
   output logic                      M_AXIS_tvalid,
   input  logic                      M_AXIS_tready,
   output logic [31:0]               M_AXIS_WIDE_tdata,
   output logic [SAT_CNT_WIDTH-1:0]  sat_count,
   output logic [DATA_WIDTH-1:0]     dbg_dc_applied
);

   localparam int DW = DATA_WIDTH;
   localparam int SW = DATA_WIDTH + 1;

   localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_FREEZE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_rdy_en;
   logic                r_s1_valid;
   logic [DW-1:0]       r_s1_ac;
   logic [DW-1:0]       r_dc_applied;
   logic                r_s2_valid;
   logic [DW-1:0]       r_s2_data;
   logic [31:0]         r_s2_wide;
   logic                r_s2_sat;
   logic [SAT_CNT_WIDTH-1:0] r_sat_count;

   logic                w_s2_load;
   logic                w_s1_load;
   logic                w_accept;
   logic                w_out_hs;
   logic                w_sat_ev;

   logic [DW-1:0]       w_in_ac;
   logic [DW-1:0]       w_in_dc;
   logic [DW-1:0]       w_dc_target;
   logic [DW-1:0]       w_dc_next;
   logic [SW-1:0]       w_applied_ext;
   logic [SW-1:0]       w_diff;
   logic [SW-1:0]       w_diff_abs;
   logic [SW-1:0]       w_slew_ext;
   logic [SW-1:0]       w_slewed;
   logic                w_slew_ok;
   logic [DW-1:0]       w_slew_val;

   logic [SW-1:0]       w_sum;
   logic                w_ovf;
   logic [DW-1:0]       w_sum_sat;

   // ------------------------------------------------------------------
   // Handshake / pipeline advance
   // ------------------------------------------------------------------
   assign w_s2_load = !r_s2_valid || M_AXIS_tready;
   assign w_s1_load = !r_s1_valid || w_s2_load;

   // r_rdy_en keeps tready low during reset and for the release cycle.
   assign S_AXIS_ACDC_tready = r_rdy_en && w_s1_load;
   assign w_accept           = S_AXIS_ACDC_tvalid && S_AXIS_ACDC_tready;
   assign w_out_hs           = r_s2_valid && M_AXIS_tready;
   assign w_sat_ev           = w_out_hs && r_s2_sat;

   assign w_in_ac = S_AXIS_ACDC_tdata[DW-1:0];
   assign w_in_dc = S_AXIS_ACDC_tdata[2*DW-1:DW];

   // ------------------------------------------------------------------
   // DC target and slew limiter
   // ------------------------------------------------------------------
   always_comb begin
      w_dc_target = r_dc_applied;
      case (dc_mode)
         2'd0:    w_dc_target = w_in_dc;
         2'd1:    w_dc_target = dc_manual;
         default: w_dc_target = r_dc_applied;
      endcase
   end

   assign w_applied_ext = {r_dc_applied[DW-1], r_dc_applied};
   assign w_diff        = {w_dc_target[DW-1], w_dc_target} - w_applied_ext;
   assign w_diff_abs    = w_diff[SW-1] ? (~w_diff + SW'(1)) : w_diff;
   assign w_slew_ext    = {{(SW-SLEW_WIDTH){1'b0}}, dc_slew};
   assign w_slew_ok     = (dc_slew == '0) || (w_diff_abs <= w_slew_ext);

   // Only used when |d| > slew, so the step lands strictly between the
   // applied value and the target and always fits back into DW bits.
   assign w_slewed   = w_diff[SW-1] ? (w_applied_ext - w_slew_ext)
                                    : (w_applied_ext + w_slew_ext);
   assign w_slew_val = w_slew_ok ? w_dc_target : w_slewed[DW-1:0];

   // ------------------------------------------------------------------
   // DC FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_INIT;
      end else if (w_accept) begin
         r_state <= w_state_next;
      end
   end

   // DC FSM: next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT:   w_state_next = dc_mode[1] ? ST_FREEZE : ST_TRACK;
         ST_TRACK:  w_state_next = dc_mode[1] ? ST_FREEZE : ST_TRACK;
         ST_FREEZE: w_state_next = dc_mode[1] ? ST_FREEZE : ST_TRACK;
         default:   w_state_next = ST_INIT;
      endcase
   end

   // DC FSM: applied DC for the beat being accepted
   always_comb begin
      w_dc_next = r_dc_applied;
      case (r_state)
         ST_INIT:   w_dc_next = dc_mode[1] ? '0 : w_dc_target;
         ST_TRACK,
         ST_FREEZE: w_dc_next = dc_mode[1] ? r_dc_applied : w_slew_val;
         default:   w_dc_next = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Stage 1: DC update and AC register
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rdy_en     <= 1'b0;
         r_s1_valid   <= 1'b0;
         r_s1_ac      <= '0;
         r_dc_applied <= '0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_s1_load) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
               r_s1_ac      <= w_in_ac;
               r_dc_applied <= w_dc_next;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: sum and saturate
   // ------------------------------------------------------------------
   assign w_sum     = {r_s1_ac[DW-1], r_s1_ac} + w_applied_ext;
   assign w_ovf     = w_sum[SW-1] ^ w_sum[SW-2];
   assign w_sum_sat = w_ovf ? (w_sum[SW-1] ? SAT_MIN : SAT_MAX) : w_sum[DW-1:0];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= '0;
         r_s2_wide  <= '0;
         r_s2_sat   <= 1'b0;
      end else if (w_s2_load) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= w_sum_sat;
            r_s2_wide <= {{(32-SW){w_sum[SW-1]}}, w_sum};
            r_s2_sat  <= w_ovf;
         end
      end
   end

   // ------------------------------------------------------------------
   // Saturation counter; a clear coinciding with a clamped handshake
   // keeps that event.
   // ------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_sat_count <= '0;
      end else if (sat_clr) begin
         r_sat_count <= w_sat_ev ? SAT_CNT_WIDTH'(1) : '0;
      end else if (w_sat_ev && (r_sat_count != '1)) begin
         r_sat_count <= r_sat_count + SAT_CNT_WIDTH'(1);
      end
   end

   assign M_AXIS_tdata      = r_s2_data;
   assign M_AXIS_tvalid     = r_s2_valid;
   assign M_AXIS_WIDE_tdata = r_s2_wide;
   assign sat_count         = r_sat_count;
   assign dbg_dc_applied    = r_dc_applied;

endmodule

// File: tb/tb_axis_dc_restore.sv
// ---------------------------------------------------------------------------
// tb_axis_dc_restore
//
// Directed bench for axis_dc_restore. Output beats are captured on each
// output handshake and compared against hand-computed sequences.
// ---------------------------------------------------------------------------
module tb_axis_dc_restore;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] S_AXIS_ACDC_tdata;
   logic        S_AXIS_ACDC_tvalid;
   logic        S_AXIS_ACDC_tready;
   logic [1:0]  dc_mode;
   logic [15:0] dc_manual;
   logic [15:0] dc_slew;
   logic        sat_clr;
   logic [15:0] M_AXIS_tdata;
   logic        M_AXIS_tvalid;
   logic        M_AXIS_tready;
   logic [31:0] M_AXIS_WIDE_tdata;
   logic [15:0] sat_count;
   logic [15:0] dbg_dc_applied;

   int checks   = 0;
   int failures = 0;
   int s_stall  = 0;

   logic [15:0] q_m[$];
   logic [31:0] q_w[$];

   axis_dc_restore #(
      .DATA_WIDTH    (16),
      .SLEW_WIDTH    (16),
      .SAT_CNT_WIDTH (16)
   ) dut (
      .aclk               (aclk),
      .aresetn            (aresetn),
      .S_AXIS_ACDC_tdata  (S_AXIS_ACDC_tdata),
      .S_AXIS_ACDC_tvalid (S_AXIS_ACDC_tvalid),
      .S_AXIS_ACDC_tready (S_AXIS_ACDC_tready),
      .dc_mode            (dc_mode),
      .dc_manual          (dc_manual),
      .dc_slew            (dc_slew),
      .sat_clr            (sat_clr),
      .M_AXIS_tdata       (M_AXIS_tdata),
      .M_AXIS_tvalid      (M_AXIS_tvalid),
      .M_AXIS_tready      (M_AXIS_tready),
      .M_AXIS_WIDE_tdata  (M_AXIS_WIDE_tdata),
      .sat_count          (sat_count),
      .dbg_dc_applied     (dbg_dc_applied)
   );

   always #5 aclk = ~aclk;

   // Capture output handshakes and input stalls half a cycle before the edge.
   always @(negedge aclk) begin
      if (aresetn && M_AXIS_tvalid && M_AXIS_tready) begin
         q_m.push_back(M_AXIS_tdata);
         q_w.push_back(M_AXIS_WIDE_tdata);
      end
      if (aresetn && S_AXIS_ACDC_tvalid && !S_AXIS_ACDC_tready)
         s_stall++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] x16(input int v);
      logic [31:0] t;
      t = v;
      return {16'h0, t[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_m(input string tag, input int idx, input int exp);
      logic [31:0] o;
      o = (idx < q_m.size()) ? {16'h0, q_m[idx]} : 32'hxxxxxxxx;
      check($sformatf("%s[%0d]", tag, idx), o, x16(exp));
   endtask

   task automatic chk_w(input string tag, input int idx, input int exp);
      logic [31:0] o;
      logic [31:0] e;
      e = exp;
      o = (idx < q_w.size()) ? q_w[idx] : 32'hxxxxxxxx;
      check($sformatf("%s[%0d]", tag, idx), o, e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   task automatic clear_q();
      q_m.delete();
      q_w.delete();
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic send(input int dc, input int ac);
      logic        acc;
      logic [31:0] d;
      logic [31:0] a;
      d   = dc;
      a   = ac;
      acc = 1'b0;
      S_AXIS_ACDC_tdata  = {d[15:0], a[15:0]};
      S_AXIS_ACDC_tvalid = 1'b1;
      for (int n = 0; n < 64 && !acc; n++) begin
         @(negedge aclk);
         acc = S_AXIS_ACDC_tready;
         @(posedge aclk);
         #1;
      end
      S_AXIS_ACDC_tvalid = 1'b0;
      if (!acc) check("send_timeout", {31'h0, acc}, 32'h1);
   endtask

   initial begin
      int e5[11];
      int e6[3];

      aresetn            = 1'b0;
      S_AXIS_ACDC_tdata  = '0;
      S_AXIS_ACDC_tvalid = 1'b0;
      dc_mode            = 2'd0;
      dc_manual          = '0;
      dc_slew            = '0;
      sat_clr            = 1'b0;
      M_AXIS_tready      = 1'b1;

      // ---- reset state ----
      tick(3);
      @(negedge aclk);
      check("rst_mdata",  {16'h0, M_AXIS_tdata},   32'h0);
      check("rst_mvalid", {31'h0, M_AXIS_tvalid},  32'h0);
      check("rst_sready", {31'h0, S_AXIS_ACDC_tready}, 32'h0);
      check("rst_sat",    {16'h0, sat_count},      32'h0);
      check("rst_dbg",    {16'h0, dbg_dc_applied}, 32'h0);
      check("rst_wide",   M_AXIS_WIDE_tdata,       32'h0);
      aresetn = 1'b1;
      #1;
      check("rel_sready_low", {31'h0, S_AXIS_ACDC_tready}, 32'h0);
      @(posedge aclk);
      #1;
      check("rel_sready_high", {31'h0, S_AXIS_ACDC_tready}, 32'h1);

      // ---- test 1: stream DC, unlimited slew, latency 2 ----
      clear_q();
      S_AXIS_ACDC_tdata  = {16'd100, 16'hFFFB};
      S_AXIS_ACDC_tvalid = 1'b1;
      tick(1);
      @(negedge aclk);
      check("t1_lat_v0", {31'h0, M_AXIS_tvalid},  32'h0);
      check("t1_dbg",    {16'h0, dbg_dc_applied}, x16(100));
      tick(1);
      @(negedge aclk);
      check("t1_lat_v1", {31'h0, M_AXIS_tvalid}, 32'h1);
      check("t1_lat_d",  {16'h0, M_AXIS_tdata},  x16(95));
      check("t1_lat_w",  M_AXIS_WIDE_tdata,      32'd95);
      tick(2);
      S_AXIS_ACDC_tvalid = 1'b0;
      tick(4);
      check("t1_count", q_m.size(), 32'd4);
      for (int i = 0; i < 4; i++) chk_m("t1_m", i, 95);

      // ---- test 2: INIT load, then slew-limited jump ----
      aresetn = 1'b0;
      tick(2);
      aresetn = 1'b1;
      tick(1);
      dc_slew = 16'd400;
      clear_q();
      send(1000, 0);
      send(0, 0);
      send(0, 0);
      send(0, 0);
      tick(4);
      check("t2_count", q_m.size(), 32'd4);
      chk_m("t2_m", 0, 1000);
      chk_m("t2_m", 1, 600);
      chk_m("t2_m", 2, 200);
      chk_m("t2_m", 3, 0);
      check("t2_dbg", {16'h0, dbg_dc_applied}, x16(0));

      // ---- test 3: saturation and sat_count ----
      dc_slew = 16'd0;
      clear_q();
      check("t3_sat0", {16'h0, sat_count}, 32'd0);
      send(32000, 1000);
      tick(4);
      chk_m("t3_m", 0, 32767);
      chk_w("t3_w", 0, 33000);
      check("t3_sat1", {16'h0, sat_count}, 32'd1);
      send(-32768, -1);
      tick(4);
      chk_m("t3_m", 1, -32768);
      chk_w("t3_w", 1, -32769);
      check("t3_sat2", {16'h0, sat_count}, 32'd2);
      sat_clr = 1'b1;
      tick(1);
      sat_clr = 1'b0;
      check("t3_clr", {16'h0, sat_count}, 32'd0);
      M_AXIS_tready = 1'b0;
      send(-32768, -1);
      tick(3);
      @(negedge aclk);
      check("t3_hold_v",   {31'h0, M_AXIS_tvalid}, 32'h1);
      check("t3_hold_d",   {16'h0, M_AXIS_tdata},  x16(-32768));
      check("t3_hold_sat", {16'h0, sat_count},     32'd0);
      tick(1);
      M_AXIS_tready = 1'b1;
      sat_clr       = 1'b1;
      tick(1);
      sat_clr = 1'b0;
      check("t3_clr_hs", {16'h0, sat_count}, 32'd1);
      tick(2);

      // ---- test 4: output backpressure 1010... ----
      clear_q();
      s_stall       = 0;
      M_AXIS_tready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) send(0, i);
         end
         begin
            for (int k = 0; k < 30; k++) begin
               @(posedge aclk);
               #1;
               M_AXIS_tready = ~M_AXIS_tready;
            end
         end
      join
      M_AXIS_tready = 1'b1;
      tick(4);
      check("t4_count", q_m.size(), 32'd8);
      for (int i = 0; i < 8; i++) chk_m("t4_m", i, i);
      chk_w("t4_w", 7, 7);
      check("t4_stalled", {31'h0, (s_stall > 0)}, 32'h1);

      // ---- test 5: freeze then manual with slew ----
      e5 = '{500, 510, 480, 400, 300, 200, 100, 0, -100, -200, -200};
      clear_q();
      send(500, 0);
      dc_mode = 2'd2;
      send(3000, 10);
      send(3000, -20);
      dc_mode   = 2'd1;
      dc_manual = 16'hFF38;
      dc_slew   = 16'd100;
      for (int i = 0; i < 8; i++) send(3000, 0);
      dc_mode = 2'd0;
      tick(4);
      check("t5_count", q_m.size(), 32'd11);
      for (int i = 0; i < 11; i++) chk_m("t5_m", i, e5[i]);
      check("t5_dbg", {16'h0, dbg_dc_applied}, x16(-200));

      // ---- test 6: reset mid-stream with output stalled ----
      dc_slew       = 16'd0;
      M_AXIS_tready = 1'b0;
      send(700, 1);
      send(700, 2);
      tick(1);
      @(negedge aclk);
      check("t6_pre_v",   {31'h0, M_AXIS_tvalid}, 32'h1);
      check("t6_pre_d",   {16'h0, M_AXIS_tdata},  x16(701));
      check("t6_pre_sat", {16'h0, sat_count},     32'd1);
      #1;
      aresetn = 1'b0;
      #1;
      check("t6_rst_v",   {31'h0, M_AXIS_tvalid},      32'h0);
      check("t6_rst_d",   {16'h0, M_AXIS_tdata},       32'h0);
      check("t6_rst_sat", {16'h0, sat_count},          32'h0);
      check("t6_rst_rdy", {31'h0, S_AXIS_ACDC_tready}, 32'h0);
      check("t6_rst_dbg", {16'h0, dbg_dc_applied},     32'h0);
      tick(2);
      M_AXIS_tready = 1'b1;
      dc_slew       = 16'd50;
      aresetn       = 1'b1;
      tick(1);
      clear_q();
      send(2000, 5);
      send(2000, 5);
      send(2100, 0);
      tick(4);
      e6 = '{2005, 2005, 2050};
      check("t6_count", q_m.size(), 32'd3);
      for (int i = 0; i < 3; i++) chk_m("t6_m", i, e6[i]);

      // ---- first beat in freeze mode after reset loads DC = 0 ----
      aresetn = 1'b0;
      tick(1);
      aresetn = 1'b1;
      tick(1);
      clear_q();
      dc_mode = 2'd2;
      send(1234, 7);
      dc_mode = 2'd0;
      dc_slew = 16'd0;
      send(300, 0);
      tick(4);
      check("t7_count", q_m.size(), 32'd2);
      chk_m("t7_m", 0, 7);
      chk_m("t7_m", 1, 300);
      check("t7_dbg", {16'h0, dbg_dc_applied}, x16(300));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
